// File: rtl/dual_shift_pkg.sv
// Shared types and sizing helpers for the dual shift-register lockstep checker.
package dual_shift_pkg;

  typedef enum logic {
    SHIFT_UP   = 1'b0,
    SHIFT_DOWN = 1'b1
  } shift_dir_e;

  // Width of a counter that must hold the value DEPTH itself.
  function automatic int FILLW(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/shift_chain.sv
// One DEPTH-stage, WIDTH-bit delay chain; DIR selects whether samples enter at
// stage 0 and leave at DEPTH-1 (SHIFT_UP) or enter at DEPTH-1 and leave at 0.
module shift_chain
  import dual_shift_pkg::*;
#(
  parameter int         WIDTH = 8,
  parameter int         DEPTH = 16,
  parameter shift_dir_e DIR   = SHIFT_UP
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clear,
  input  logic             i_ce,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_tail
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    if (DIR == SHIFT_UP) begin : g_up
      if (gi == 0) begin : g_head
        assign stage_d[gi] = i_data;
      end else begin : g_body
        assign stage_d[gi] = stage_q[gi-1];
      end
    end else begin : g_down
      if (gi == DEPTH - 1) begin : g_head
        assign stage_d[gi] = i_data;
      end else begin : g_body
        assign stage_d[gi] = stage_q[gi+1];
      end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
        stage_q[gi] <= '0;
      end else if (i_clear) begin
        stage_q[gi] <= '0;
      end else if (i_ce) begin
        stage_q[gi] <= stage_d[gi];
      end
    end
  end

  if (DIR == SHIFT_UP) begin : g_tail_up
    assign o_tail = stage_q[DEPTH-1];
  end else begin : g_tail_down
    assign o_tail = stage_q[0];
  end

endmodule

// File: rtl/dual_shift_checker.sv
// Lockstep checker: the same stream runs through two opposite-direction chains
// whose tails must agree once full. Optional capture: DUAL_SHIFT_CAPTURE_EN.
module dual_shift_checker
  import dual_shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int CNTW  = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_ce,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_clear,
  input  logic [WIDTH-1:0] i_inject,
  output logic [WIDTH-1:0] o_data,
  output logic [WIDTH-1:0] o_data_b,
  output logic             o_valid,
  output logic             o_mismatch,
  output logic             o_err,
`ifdef DUAL_SHIFT_CAPTURE_EN
  output logic [WIDTH-1:0] o_cap_a,
  output logic [WIDTH-1:0] o_cap_b,
  output logic [FILLW(DEPTH)+CNTW-1:0] o_cap_idx,
`endif
  output logic [CNTW-1:0]  o_err_count
);

  localparam int            FW       = FILLW(DEPTH);
  localparam logic [FW-1:0] FILL_MAX = FW'(DEPTH);

  logic [WIDTH-1:0] tail_a;
  logic [WIDTH-1:0] tail_b;
  logic [WIDTH-1:0] data_b;

  logic [FW-1:0]    fill_q, fill_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic [CNTW-1:0]  err_count_q, err_count_d;
  logic             err_event;

  // Fault injection only perturbs chain B so the two copies diverge.
  assign data_b = i_data ^ i_inject;

  shift_chain #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .DIR   (SHIFT_UP)
  ) u_chain_a (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clear (i_clear),
    .i_ce    (i_ce),
    .i_data  (i_data),
    .o_tail  (tail_a)
  );

  shift_chain #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .DIR   (SHIFT_DOWN)
  ) u_chain_b (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clear (i_clear),
    .i_ce    (i_ce),
    .i_data  (data_b),
    .o_tail  (tail_b)
  );

  assign o_data     = tail_a;
  assign o_data_b   = tail_b;
  assign o_valid    = valid_q;
  assign o_mismatch = valid_q && (tail_a != tail_b);
  assign o_err      = err_q;
  assign o_err_count = err_count_q;

  // The check judges the tails currently presented, before this shift lands.
  assign err_event = i_ce && o_mismatch;

  always_comb begin
    fill_d      = fill_q;
    valid_d     = valid_q;
    err_d       = err_q;
    err_count_d = err_count_q;
    if (i_clear) begin
      fill_d      = '0;
      valid_d     = 1'b0;
      err_d       = 1'b0;
      err_count_d = '0;
    end else if (i_ce) begin
      if (fill_q != FILL_MAX) begin
        fill_d = fill_q + 1'b1;
      end
      valid_d = (fill_d == FILL_MAX);
      if (err_event) begin
        err_d = 1'b1;
        if (err_count_q != '1) begin
          err_count_d = err_count_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      fill_q      <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      err_count_q <= '0;
    end else begin
      fill_q      <= fill_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
    end
  end

`ifdef DUAL_SHIFT_CAPTURE_EN
  localparam int IDXW = FW + CNTW;

  logic [IDXW-1:0]  ev_q, ev_d;
  logic [WIDTH-1:0] cap_a_q, cap_a_d;
  logic [WIDTH-1:0] cap_b_q, cap_b_d;
  logic [IDXW-1:0]  cap_idx_q, cap_idx_d;

  // Only the first error-updating mismatch is latched: err_q still low.
  always_comb begin
    ev_d      = ev_q;
    cap_a_d   = cap_a_q;
    cap_b_d   = cap_b_q;
    cap_idx_d = cap_idx_q;
    if (i_clear) begin
      ev_d      = '0;
      cap_a_d   = '0;
      cap_b_d   = '0;
      cap_idx_d = '0;
    end else if (i_ce) begin
      if (ev_q != '1) begin
        ev_d = ev_q + 1'b1;
      end
      if (err_event && !err_q) begin
        cap_a_d   = tail_a;
        cap_b_d   = tail_b;
        cap_idx_d = ev_q;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ev_q      <= '0;
      cap_a_q   <= '0;
      cap_b_q   <= '0;
      cap_idx_q <= '0;
    end else begin
      ev_q      <= ev_d;
      cap_a_q   <= cap_a_d;
      cap_b_q   <= cap_b_d;
      cap_idx_q <= cap_idx_d;
    end
  end

  assign o_cap_a   = cap_a_q;
  assign o_cap_b   = cap_b_q;
  assign o_cap_idx = cap_idx_q;
`endif

endmodule

// File: tb/tb_dual_shift_checker.sv
// Directed bench: a queue-based delay-line model checked every cycle, plus
// hand-computed literal checks at the interesting points.
module tb_dual_shift_checker;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int CNTW  = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             ce = 1'b0;
  logic             clr = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic [WIDTH-1:0] inj = '0;

  logic [WIDTH-1:0] o_data, o_data_b;
  logic             o_valid, o_mismatch, o_err;
  logic [CNTW-1:0]  o_err_count;

  int n_cmp  = 0;
  int n_fail = 0;

  dual_shift_checker #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .CNTW  (CNTW)
  ) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_ce        (ce),
    .i_data      (din),
    .i_clear     (clr),
    .i_inject    (inj),
    .o_data      (o_data),
    .o_data_b    (o_data_b),
    .o_valid     (o_valid),
    .o_mismatch  (o_mismatch),
    .o_err       (o_err),
    .o_err_count (o_err_count)
  );

  always #5 clk = ~clk;

  // Model: each chain is just "the sample taken DEPTH events ago".
  logic [WIDTH-1:0] qa[$];
  logic [WIDTH-1:0] qb[$];
  int               m_events;
  bit               m_err;
  int               m_cnt;

  function automatic void model_reset();
    qa.delete();
    qb.delete();
    for (int i = 0; i < DEPTH; i++) begin
      qa.push_back('0);
      qb.push_back('0);
    end
    m_events = 0;
    m_err    = 1'b0;
    m_cnt    = 0;
  endfunction

  function automatic bit m_valid();
    return m_events >= DEPTH;
  endfunction

  function automatic bit m_mismatch();
    return m_valid() && (qa[DEPTH-1] != qb[DEPTH-1]);
  endfunction

  initial model_reset();

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_reset();
    end else if (clr) begin
      model_reset();
    end else if (ce) begin
      if (m_mismatch()) begin
        m_err = 1'b1;
        if (m_cnt < (1 << CNTW) - 1) m_cnt = m_cnt + 1;
      end
      qa.push_front(din);
      void'(qa.pop_back());
      qb.push_front(din ^ inj);
      void'(qb.pop_back());
      m_events = m_events + 1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("cyc_data",     int'(o_data),      int'(qa[DEPTH-1]));
    chk("cyc_data_b",   int'(o_data_b),    int'(qb[DEPTH-1]));
    chk("cyc_valid",    int'(o_valid),     int'(m_valid()));
    chk("cyc_mismatch", int'(o_mismatch),  int'(m_mismatch()));
    chk("cyc_err",      int'(o_err),       int'(m_err));
    chk("cyc_count",    int'(o_err_count), m_cnt);
  end

  task automatic step(input logic c, input logic [WIDTH-1:0] d,
                      input logic [WIDTH-1:0] m, input logic cl);
    ce  = c;
    din = d;
    inj = m;
    clr = cl;
    @(posedge clk);
    #1;
    ce  = 1'b0;
    clr = 1'b0;
    inj = '0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_valid", int'(o_valid), 0);
    chk("rst_data",  int'(o_data), 0);
    chk("rst_count", int'(o_err_count), 0);
    $display("reset released");

    // Fill: 15 events leave the pipe not yet valid.
    for (int i = 0; i < DEPTH - 1; i++) step(1'b1, WIDTH'(i), '0, 1'b0);
    chk("fill15_valid", int'(o_valid), 0);
    step(1'b1, 8'h0F, '0, 1'b0);
    chk("fill16_valid",  int'(o_valid), 1);
    chk("fill16_data",   int'(o_data), 8'h00);
    chk("fill16_data_b", int'(o_data_b), 8'h00);
    $display("fill: o_valid=%0d o_data=%02h o_data_b=%02h", o_valid, o_data, o_data_b);
    step(1'b1, 8'h10, '0, 1'b0);
    chk("next_data", int'(o_data), 8'h01);
    $display("next: o_data=%02h", o_data);

    // A stall holds everything.
    step(1'b0, 8'hEE, '0, 1'b0);
    chk("stall_data", int'(o_data), 8'h01);

    for (int i = 0; i < 100; i++) step(1'b1, WIDTH'($urandom_range(0, 255)), '0, 1'b0);
    chk("clean_err",   int'(o_err), 0);
    chk("clean_count", int'(o_err_count), 0);
    $display("random clean: o_err=%0d count=%0d", o_err, o_err_count);

    // Single injected fault reaches the tails DEPTH-1 events later.
    step(1'b1, 8'hA5, 8'h01, 1'b0);
    for (int i = 0; i < DEPTH - 1; i++) step(1'b1, WIDTH'(8'h30 + i), '0, 1'b0);
    chk("inj_mismatch", int'(o_mismatch), 1);
    chk("inj_data",     int'(o_data), 8'hA5);
    chk("inj_data_b",   int'(o_data_b), 8'hA4);
    chk("inj_err_pre",  int'(o_err), 0);
    step(1'b0, 8'h00, '0, 1'b0);
    chk("inj_err_noce", int'(o_err), 0);
    step(1'b1, 8'h40, '0, 1'b0);
    chk("inj_err",   int'(o_err), 1);
    chk("inj_count", int'(o_err_count), 1);
    $display("inject: o_err=%0d count=%0d", o_err, o_err_count);

    for (int i = 0; i < 300; i++) step(1'b1, WIDTH'(i), 8'hFF, 1'b0);
    chk("sat_count", int'(o_err_count), 255);
    chk("sat_err",   int'(o_err), 1);
    $display("saturate: count=%0d", o_err_count);

    // Clear wins over ce; the sample must not enter.
    step(1'b1, 8'h77, '0, 1'b1);
    chk("clr_valid", int'(o_valid), 0);
    chk("clr_err",   int'(o_err), 0);
    chk("clr_count", int'(o_err_count), 0);
    for (int i = 0; i < DEPTH - 1; i++) step(1'b1, WIDTH'(8'h50 + i), '0, 1'b0);
    chk("clr_drop_valid", int'(o_valid), 0);
    step(1'b1, 8'h5F, '0, 1'b0);
    chk("clr_drop_data", int'(o_data), 8'h50);
    $display("clear: o_data=%02h", o_data);

    // Async reset mid-fill, between clock edges.
    step(1'b1, 8'h11, '0, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b1, WIDTH'(8'h60 + i), '0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("arst_data",   int'(o_data), 0);
    chk("arst_data_b", int'(o_data_b), 0);
    chk("arst_valid",  int'(o_valid), 0);
    #1 rst = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) step(1'b1, WIDTH'(8'h80 + i), '0, 1'b0);
    chk("arst_fill15", int'(o_valid), 0);
    step(1'b1, 8'h8F, '0, 1'b0);
    chk("arst_fill16", int'(o_valid), 1);
    chk("arst_data16", int'(o_data), 8'h80);
    $display("async reset refill: o_valid=%0d o_data=%02h", o_valid, o_data);

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dual_shift_checker.md
Name: dual_shift_checker

Overview:
- Parametrised successor to the team's single-bit dual shift-register self-check.
- Two independent DEPTH-stage, WIDTH-bit delay chains carry the same input stream in opposite shift directions:
  - chain A inserts at index 0 and exits at DEPTH-1;
  - chain B inserts at DEPTH-1 and exits at 0.
- Chain outputs are compared once the pipeline is full, giving a lockstep fault detector with sticky error, saturating error count and a fault-injection hook.
- Sits beside any delay line needing redundancy checking; also the quiz-series vehicle for induction/invariant exercises.

Parameters:
- WIDTH, 8, bits per sample (>=1)
- DEPTH, 16, stages per chain (>=2)
- CNTW, 8, width of saturating mismatch counter (>=1)

Ports:
- i_clk  in  1  clock, all state on rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_ce  in  1  shift enable; both chains advance together
- i_data  in  WIDTH  sample written into both chains when i_ce
- i_clear  in  1  synchronous clear of chains, fill state and error state
- i_inject  in  WIDTH  XOR mask applied to chain B's input only on i_ce cycles; 0 = no fault
- o_data  out  WIDTH  chain A tail (stage DEPTH-1)
- o_data_b  out  WIDTH  chain B tail (stage 0)
- o_valid  out  1  high once DEPTH samples have been shifted in since reset/clear
- o_mismatch  out  1  combinational: o_valid && (o_data != o_data_b)
- o_err  out  1  sticky mismatch flag
- o_err_count  out  CNTW  saturating count of cycles with o_mismatch && i_ce

Behaviour:
- Reset (async assert, sync-safe deassert): all chain stages 0, fill counter 0, o_valid 0, o_err 0, o_err_count 0. Outputs are therefore o_data = o_data_b = 0 and o_mismatch = 0.
- On i_ce, chain A shifts: A[0] <= i_data, A[k] <= A[k-1].
- On i_ce, chain B shifts: B[DEPTH-1] <= i_data ^ i_inject, B[k] <= B[k+1].
- No i_ce: all state holds, including counters and flags.
- Latency: a sample taken at i_ce event n appears on both tails after event n+DEPTH-1, i.e. it is visible once DEPTH i_ce events have occurred in total.
- Fill counter: width $clog2(DEPTH+1); increments on i_ce; saturates at DEPTH. o_valid = (fill == DEPTH), registered.
- Error update on i_ce with o_mismatch: o_err <= 1; o_err_count <= o_err_count+1, saturating at all-ones.
  - The check uses pre-shift tails, i.e. the value currently presented.
- Mismatch with i_ce low: visible on o_mismatch; o_err and count do not update.
- i_clear: same effect as reset but synchronous. It has priority over a simultaneous i_ce; that sample is dropped.
- Reset mid-fill or mid-error: state returns to reset values immediately; there is no partial retention.
- Invariant (with i_inject == 0 since last clear): A[k] == B[DEPTH-1-k] for all k, so o_mismatch never asserts. Formal must prove this by induction.

Optional Feature:
- Macro DUAL_SHIFT_CAPTURE_EN.
- Defined: adds outputs o_cap_a, o_cap_b (WIDTH each) and o_cap_idx ($clog2(DEPTH+1)+CNTW bits, free-running i_ce event count since clear, saturating).
  - These latch the tails and event count on the first error-updating mismatch only.
  - They clear on reset/i_clear.
- Undefined: these ports and registers do not exist; remaining behaviour is unchanged.

Decomposition:
- Package dual_shift_pkg:
  - function clog2-based FILLW(DEPTH);
  - enum for shift direction (SHIFT_UP, SHIFT_DOWN).
- One sub-module shift_chain:
  - parameters WIDTH, DEPTH, DIR;
  - inputs i_clk, i_reset, i_clear, i_ce, i_data;
  - output o_tail.
  - Instantiated twice.
- Compare, fill and error logic lives in the top level.

Test Plan:
- Reset, then 15 i_ce with i_data=0x00..0x0E -> o_valid=0. On the 16th -> o_valid=1, o_data=o_data_b=0x00. Next ce -> 0x01.
- 100 i_ce of random data, i_inject=0 -> o_mismatch never 1, o_err=0, o_err_count=0.
- One ce with i_inject=0x01 and i_data=0xA5, then 15 clean ce's -> mismatch appears with o_data=0xA5, o_data_b=0xA4. On the next ce: o_err=1, count=1 (capture: cap_a=0xA5, cap_b=0xA4).
- Continuous i_inject=0xFF for 300 valid ce's, CNTW=8 -> o_err_count saturates at 255, o_err=1.
- i_clear and i_ce together after an error -> all state 0, o_valid=0, o_err=0, count=0, and the sample is not loaded.
- Async i_reset pulse between clock edges mid-fill (fill=7) -> outputs 0 immediately. The fill restarts and o_valid rises on the 16th subsequent ce.
